// File: rtl/mul_pkg.sv
// Shared constants and FSM state encoding for the multi-cycle MUL sequencer.
package mul_pkg;

  localparam int MUL_WIDTH = 64;
  localparam int MUL_CNT_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/adder.sv
// Plain WIDTH-bit adder shared with the datapath; the carry-out is not kept.
module adder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum
);

  assign sum = x + y;

endmodule

// File: rtl/mul_sequencer.sv
// Shift-and-add multiplier controller: one adder, one multiplier bit per RUN cycle,
// early exit once the remaining multiplier bits are all zero.
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  mul_state_t       state, state_d;
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [WIDTH-1:0] add_sum, acc_next;
  logic [CNT_W-1:0] count;
  logic             last;

  adder #(.WIDTH(WIDTH)) u_acc_adder (
    .x   (acc),
    .y   (mcand),
    .sum (add_sum)
  );

  assign acc_next = mplier[0] ? add_sum : acc;
  assign last     = ((mplier >> 1) == '0) || (count == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      // The unused 2'b11 encoding falls back to IDLE.
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      state <= state_d;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
          end
        end
        ST_RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CNT_W'(1);
          if (last) product <= acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule
